// File: rtl/rename_tag_allocator.sv
// rename_tag_allocator
// Circular, in-order allocator of in-flight destination tags. The issue stage
// takes the tag at the tail, commit retires the tag at the head, and a branch
// miss flashes the tail back to just after the mispredicted branch's tag.
// Occupancy is tracked by an explicit counter so full and empty are
// distinguishable when head == tail.
module rename_tag_allocator #(
  parameter  int NUM_TAG = 64,
  localparam int IDX_W   = $clog2(NUM_TAG)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               alloc_req,
  output logic               alloc_ack,
  output logic [NUM_TAG-1:0] alloc_tag,
  output logic [IDX_W-1:0]   alloc_idx,
  output logic               full,
  output logic               empty,
  output logic [IDX_W:0]     count,
  output logic [NUM_TAG-1:0] head_tag,
  output logic [IDX_W-1:0]   head_idx,
  input  logic               commit_en,
  input  logic               flash,
  input  logic [IDX_W-1:0]   flash_idx,
  output logic               flash_err
);

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   cnt;

  logic [IDX_W-1:0] head_nxt;
  logic [IDX_W-1:0] tail_nxt;
  logic [IDX_W:0]   cnt_nxt;

  logic             commit_acc;
  logic [IDX_W-1:0] flash_dist;
  logic             flash_valid;

  // Status and tag outputs decode registered state only (no lookahead).
  assign full      = cnt[IDX_W];
  assign empty     = (cnt == '0);
  assign count     = cnt;
  assign alloc_idx = tail;
  assign head_idx  = head;
  assign alloc_tag = NUM_TAG'(1) << tail;
  assign head_tag  = NUM_TAG'(1) << head;

  // A full allocator refuses allocation even if a commit frees a slot this
  // cycle; any flash also blocks allocation.
  assign alloc_ack  = alloc_req && !full && !flash;
  assign commit_acc = commit_en && !empty;

  // The branch tag is in flight iff its age (distance from head) is below cnt.
  assign flash_dist  = flash_idx - head;
  assign flash_valid = flash && ({1'b0, flash_dist} < cnt);

  // Next-state computation for head, tail and occupancy.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    head_nxt = head + IDX_W'(commit_acc);
    tail_nxt = tail;
    cnt_nxt  = cnt;
    if (flash_valid) begin
      // Keep everything up to and including the branch; a same-cycle commit
      // still retires the oldest, which empties the window if that is the branch.
      tail_nxt = flash_idx + IDX_W'(1);
      cnt_nxt  = {1'b0, flash_dist} + (IDX_W+1)'(1) - (IDX_W+1)'(commit_acc);
    end else begin
      tail_nxt = tail + IDX_W'(alloc_ack);
      cnt_nxt  = cnt + (IDX_W+1)'(alloc_ack) - (IDX_W+1)'(commit_acc);
    end
  end

  // State registers; flash_err is a one-cycle pulse per invalid flash.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      flash_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      head      <= head_nxt;
      tail      <= tail_nxt;
      cnt       <= cnt_nxt;
      flash_err <= flash && !flash_valid;
    end
  end

  // Occupancy always equals the pointer distance; cnt == NUM_TAG aliases to 0.
  assert property (@(posedge clock) disable iff (!reset)
    (cnt[IDX_W-1:0] == IDX_W'(tail - head)) && (cnt <= (IDX_W+1)'(NUM_TAG)));

endmodule
